// File: rtl/rom_sample_player.sv
// One-channel ROMIntegrator client: steps AccessIndex once per sample period, prefetches the
// sample after the integrator latency and presents it as a registered output, one-shot or looped.
module rom_sample_player #(
  parameter int unsigned SAMPLE_DIV  = 6250,
  parameter int unsigned ROM_LATENCY = 8
) (
  input  logic        CLK_50Mhz,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        loop_en_i,
  input  logic [15:0] sampleLength_i,
  input  logic [15:0] romData_i,
  output logic [15:0] accessIndex_o,
  output logic [15:0] accessMaxIndex_o,
  output logic [15:0] sampleOut_o,
  output logic        sampleValid_o,
  output logic        playing_o,
  output logic        done_o
);

  // state     | meaning
  // S_IDLE    | no playback, waiting for start
  // S_SETTLE  | index presented, waiting ROM_LATENCY cycles before prefetch
  // S_WAIT    | prefetched sample held until the next period tick
  // S_LAST    | final sample shown, ends playback on the next tick
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_LAST} state_t;

  localparam logic [15:0] TICK_LAST   = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(ROM_LATENCY - 1);

  state_t      state_q;
  logic [1:0]  rst_sync_q;
  logic        rst_n;
  logic [15:0] tick_cnt_q;
  logic [15:0] settle_cnt_q;
  logic [15:0] len_q;
  logic [15:0] prefetch_q;
  logic [15:0] index_q;
  logic [15:0] max_index_q;
  logic [15:0] sample_q;
  logic        valid_q;
  logic        done_q;
  logic        playing_q;
  logic        tick;
  logic [15:0] last_idx;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign last_idx = len_q - 16'd1;

  always_ff @(posedge CLK_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      settle_cnt_q <= '0;
      len_q        <= '0;
      prefetch_q   <= '0;
      index_q      <= '0;
      max_index_q  <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != S_IDLE) tick_cnt_q <= tick ? '0 : tick_cnt_q + 16'd1;

      if (stop_i) begin
        state_q    <= S_IDLE;
        tick_cnt_q <= '0;
        sample_q   <= '0;
        index_q    <= '0;
        playing_q  <= 1'b0;
      end else if (start_i) begin
        // Same path from idle and while playing; the period restarts from the accepted start.
        len_q       <= sampleLength_i;
        max_index_q <= sampleLength_i;
        tick_cnt_q  <= '0;
        if (sampleLength_i == 16'd0) begin
          state_q   <= S_IDLE;
          done_q    <= 1'b1;
          sample_q  <= '0;
          playing_q <= 1'b0;
        end else begin
          state_q      <= S_SETTLE;
          index_q      <= '0;
          settle_cnt_q <= '0;
          playing_q    <= 1'b1;
        end
      end else begin
        case (state_q)
          S_SETTLE: begin
            settle_cnt_q <= settle_cnt_q + 16'd1;
            if (settle_cnt_q == SETTLE_LAST) begin
              prefetch_q <= romData_i;
              state_q    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (tick) begin
              sample_q <= prefetch_q;
              valid_q  <= 1'b1;
              if (index_q < last_idx) begin
                index_q      <= index_q + 16'd1;
                settle_cnt_q <= '0;
                state_q      <= S_SETTLE;
              end else if (loop_en_i) begin
                index_q      <= '0;
                settle_cnt_q <= '0;
                state_q      <= S_SETTLE;
              end else begin
                state_q <= S_LAST;
              end
            end
          end
          S_LAST: begin
            if (tick) begin
              sample_q  <= '0;
              done_q    <= 1'b1;
              playing_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign accessIndex_o    = index_q;
  assign accessMaxIndex_o = max_index_q;
  assign sampleOut_o      = sample_q;
  assign sampleValid_o    = valid_q;
  assign playing_o        = playing_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_rom_sample_player.sv
// Scoreboard bench for rom_sample_player: playback plans are expanded into expected
// sample/done events at start time and matched by a monitor one step after each clock edge.
module tb_rom_sample_player;
  localparam int SD = 8;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [15:0] len_in = '0;
  logic [15:0] rom_data = '0;
  logic [15:0] idx_d1 = '0;
  logic [15:0] accessIndex;
  logic [15:0] accessMaxIndex;
  logic [15:0] sampleOut;
  logic        sampleValid;
  logic        playing;
  logic        done;

  rom_sample_player #(.SAMPLE_DIV(SD), .ROM_LATENCY(RL)) dut (
    .CLK_50Mhz       (clk),
    .reset_n         (reset_n),
    .start_i         (start),
    .stop_i          (stop),
    .loop_en_i       (loop_en),
    .sampleLength_i  (len_in),
    .romData_i       (rom_data),
    .accessIndex_o   (accessIndex),
    .accessMaxIndex_o(accessMaxIndex),
    .sampleOut_o     (sampleOut),
    .sampleValid_o   (sampleValid),
    .playing_o       (playing),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: data for a new index is presented before the third edge after the change.
  always @(posedge clk) begin
    idx_d1   <= accessIndex;
    rom_data <= 16'h1000 + idx_d1;
  end

  typedef struct {
    int          cyc;
    bit          is_done;
    logic [15:0] val;
  } ev_t;

  ev_t         sbq[$];
  ev_t         ev;
  int          total = 0;
  int          bad = 0;
  int          play_start = 0;
  int          play_end = 0;
  int          clear_at = -1;
  logic [15:0] exp_sample = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void flush_from(input int c);
    ev_t keep[$];
    foreach (sbq[i]) if (sbq[i].cyc < c) keep.push_back(sbq[i]);
    sbq = keep;
  endfunction

  // Plays 'passes' full passes of the clip starting at edge c, then a done one period later.
  function automatic void push_plan(input int c, input int len, input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        sbq.push_back('{c + SD * (p * len + i + 1), 1'b0, 16'h1000 + 16'(i)});
    sbq.push_back('{c + SD * (passes * len + 1), 1'b1, 16'h0000});
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue_start(input int len, input bit lp, input int passes, output int c);
    c       = cyc + 1;
    start   = 1'b1;
    len_in  = 16'(len);
    loop_en = lp;
    flush_from(c);
    if (len == 0) begin
      sbq.push_back('{c, 1'b1, 16'h0000});
      if (play_end > c) play_end = c;
      clear_at = c;
    end else begin
      if (!(play_start <= c - 1 && c - 1 < play_end)) play_start = c;
      push_plan(c, len, passes);
      play_end = c + SD * (passes * len + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_stop();
    int c;
    c    = cyc + 1;
    stop = 1'b1;
    flush_from(c);
    if (play_end > c) play_end = c;
    clear_at = c;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout_pending", sbq.size(), 0);
    repeat (SD + 2) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (cyc == clear_at) exp_sample = 16'h0000;
    if (sampleValid || done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse_valid_done", {30'd0, sampleValid, done}, 32'd0);
      end else begin
        ev = sbq.pop_front();
        chk("event_cycle", cyc, ev.cyc);
        chk("event_done", done, ev.is_done);
        chk("event_valid", sampleValid, !ev.is_done);
        exp_sample = ev.val;
      end
    end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      chk("missed_event_cycle", cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    chk("sampleOut", sampleOut, exp_sample);
    chk("playing", playing, (cyc >= play_start && cyc < play_end));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, l, l2, p, mode, off, t, tc;
    bit lp;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_sampleOut", sampleOut, 0);
    chk("rst_sampleValid", sampleValid, 0);
    chk("rst_done", done, 0);
    chk("rst_playing", playing, 0);
    chk("rst_accessIndex", accessIndex, 0);
    chk("rst_accessMaxIndex", accessMaxIndex, 0);

    // one-shot, len 4
    issue_start(4, 1'b0, 1, c);
    chk("maxIndex_latched", accessMaxIndex, 4);
    wait_until(c + SD * 4 + 2);
    chk("last_holds_index", accessIndex, 3);
    drain();
    chk("idle_after_oneshot", playing, 0);
    repeat (2) begin
      l = $urandom_range(1, 6);
      issue_start(l, 1'b0, 1, c);
      drain();
    end

    // loop len 3 for two passes, then a random loop
    issue_start(3, 1'b1, 2, c);
    wait_until(c + SD * 3 + 1);
    loop_en = 1'b0;
    drain();
    l = $urandom_range(1, 4);
    p = $urandom_range(2, 3);
    issue_start(l, 1'b1, p, c);
    wait_until(c + SD * (p - 1) * l + 1);
    loop_en = 1'b0;
    drain();

    // stop at +13 during len 10, then start+stop together
    issue_start(10, 1'b0, 1, c);
    wait_until(c + 12);
    issue_stop();
    chk("stop_index_zero", accessIndex, 0);
    chk("stop_sampleOut_zero", sampleOut, 0);
    chk("stop_playing_low", playing, 0);
    stop = 1'b1; start = 1'b1; len_in = 16'd5;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    repeat (2 * SD) @(negedge clk);
    chk("start_stop_stays_idle", playing, 0);

    // retrigger at +20
    issue_start(6, 1'b0, 1, c);
    wait_until(c + 19);
    issue_start(6, 1'b0, 1, c2);
    drain();

    // zero length
    issue_start(0, 1'b0, 1, c);
    drain();
    chk("zero_len_maxIndex", accessMaxIndex, 0);

    // async reset at +17
    issue_start(5, 1'b0, 1, c);
    wait_until(c + 16);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    sbq.delete();
    play_end = cyc;
    exp_sample = 16'h0000;
    #1;
    chk("mid_rst_sampleOut", sampleOut, 0);
    chk("mid_rst_playing", playing, 0);
    chk("mid_rst_accessIndex", accessIndex, 0);
    chk("mid_rst_accessMaxIndex", accessMaxIndex, 0);
    chk("mid_rst_pulses", {sampleValid, done}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * SD) @(negedge clk);
    chk("idle_after_reset", playing, 0);
    issue_start(2, 1'b0, 1, c);
    drain();

    // random plays with random stop/retrigger points
    repeat (8) begin
      l    = $urandom_range(1, 6);
      lp   = 1'($urandom_range(0, 1));
      p    = lp ? 2 : 1;
      mode = $urandom_range(0, 2);
      issue_start(l, lp, p, c);
      tc   = c + SD * (p - 1) * l + 1;
      off  = $urandom_range(1, SD * (p * l + 1));
      t    = c + off;
      if (mode == 0) begin
        if (lp) begin
          wait_until(tc);
          loop_en = 1'b0;
        end
      end else begin
        if (lp && tc < t - 1) begin
          wait_until(tc);
          loop_en = 1'b0;
        end
        wait_until(t - 1);
        if (mode == 1) begin
          issue_stop();
          loop_en = 1'b0;
        end else begin
          l2 = $urandom_range(1, 4);
          issue_start(l2, 1'b0, 1, c2);
        end
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
